// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Each cycle at most one request is accepted. The chosen operands and command
// go through the ALU. The result is registered, tagged with the requester ID,
// into a one-entry output buffer.
//
// Build option: ALU_ARB_RR_EN
//   defined   -> round-robin tie-break; the port not granted last time wins.
//   undefined -> fixed priority; port 0 always wins a tie.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous, active-low reset
//   req0_valid/cmd/a/b/ready port 0 request handshake
//   req1_valid/cmd/a/b/ready port 1 request handshake
//   res_valid/id/data/err    registered result and its tag
//   res_ready                consumer takes the result
//
// Handshake rules:
//   - A transfer happens on a clock edge when valid and ready are both high.
//   - reqN_ready may depend on both reqN_valid inputs and on res_ready, all
//     combinationally.
//   - A requester whose ready is low must hold its request stable.
//   - res_valid and res_data never depend combinationally on res_ready.

// Single-cycle combinational ALU. An illegal command yields 0 and flags it.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);
    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (cmd)
            4'b0000: y = a + b;
            4'b0010: y = a - b;
            4'b0100: y = a & b;
            4'b0101: y = a | b;
            4'b0110: y = ~(a | b);
            4'b0111: y = a ^ b;
            // Shift by the full b. Oversized amounts give 0, or a full sign
            // fill for SRA.
            4'b1000: y = a << b;
            4'b1001: y = $signed(a) >>> b;
            4'b1010: y = a >> b;
            default: illegal = 1'b1;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_cmd,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_cmd,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    input  logic             res_ready
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t state, state_next;

    logic             any_valid;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_illegal;

`ifdef ALU_ARB_RR_EN
    // Port granted at the most recent acceptance. Resets to 1 so that
    // port 0 wins the first tie.
    logic last;
`endif

    assign any_valid = req0_valid | req1_valid;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            grant = ~last;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // A full buffer that drains this edge can take a new result at the same
    // edge. Readies are held low while reset is asserted.
    assign can_accept = rst & ((state == EMPTY) | res_ready);
    assign accept     = can_accept & any_valid;
    assign req0_ready = can_accept & any_valid & ~grant;
    assign req1_ready = can_accept & any_valid & grant;

    // Idle ALU inputs are forced to zero, so a port that does not win does
    // not toggle the ALU.
    always_comb begin
        alu_cmd = 4'b0000;
        alu_a   = '0;
        alu_b   = '0;
        if (any_valid) begin
            if (grant) begin
                alu_cmd = req1_cmd;
                alu_a   = req1_a;
                alu_b   = req1_b;
            end else begin
                alu_cmd = req0_cmd;
                alu_a   = req0_a;
                alu_b   = req0_b;
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .cmd     (alu_cmd),
        .a       (alu_a),
        .b       (alu_b),
        .y       (alu_y),
        .illegal (alu_illegal)
    );

    // Output buffer FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) state_next = FULL;
            end
            FULL: begin
                if (accept)         state_next = FULL;
                else if (res_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    assign res_valid = (state == FULL);

    // The result fields change only on acceptance. A drain with no new
    // acceptance leaves them unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_data <= '0;
            res_id   <= 1'b0;
            res_err  <= 1'b0;
        end else if (accept) begin
            res_data <= alu_y;
            res_id   <= grant;
            res_err  <= alu_illegal;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter.
//
// A behavioural model tracks the following from the operation rules:
//   - whether the buffer is full;
//   - the last result;
//   - the tie winner.
//
// Requests are kept in per-port "pending" slots. Each slot is held until the
// model says it was taken.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [3:0]   req0_cmd, req1_cmd;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_id, res_err;
    logic [W-1:0] res_data;
    logic         res_ready;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_cmd   (req0_cmd),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cmd   (req1_cmd),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    // Pending requests, one slot per port.
    logic         p_valid [2];
    logic [3:0]   p_cmd   [2];
    logic [W-1:0] p_a     [2];
    logic [W-1:0] p_b     [2];

    // Model state.
    logic         m_full, m_id, m_err, m_last;
    logic [W-1:0] m_data;

    logic obs_r0, obs_r1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] legal_cmds [9] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [3:0] bad_cmds   [7] = '{4'h1, 4'h3, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ALU reference written from the command table.
    function automatic void ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic e);
        e = 1'b0;
        r = '0;
        case (c)
            4'h0: r = a + b;
            4'h2: r = a - b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = ~(a | b);
            4'h7: r = a ^ b;
            4'h8: r = (b >= W) ? '0 : (a << b[4:0]);
            4'h9: begin
                if (b >= W) r = {W{a[W-1]}};
                else begin
                    r = a >> b[4:0];
                    for (int k = 0; k < W; k++)
                        if (k >= W - int'(b[4:0])) r[k] = a[W-1];
                end
            end
            4'hA: r = (b >= W) ? '0 : (a >> b[4:0]);
            default: e = 1'b1;
        endcase
    endfunction

    function automatic logic tie_port();
`ifdef ALU_ARB_RR_EN
        return ~m_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic issue(input int p, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        p_valid[p] = 1'b1;
        p_cmd[p]   = c;
        p_a[p]     = a;
        p_b[p]     = b;
    endtask

    // One clock cycle:
    //   1. drive the pending requests;
    //   2. check the readies mid-cycle;
    //   3. advance the model at the edge;
    //   4. check the outputs just after the edge.
    task automatic run_cycle();
        logic         can_acc, any, g, e;
        logic [W-1:0] r;
        req0_valid = p_valid[0];
        req0_cmd   = p_cmd[0];
        req0_a     = p_a[0];
        req0_b     = p_b[0];
        req1_valid = p_valid[1];
        req1_cmd   = p_cmd[1];
        req1_a     = p_a[1];
        req1_b     = p_b[1];
        @(negedge clk);
        can_acc = rst && (!m_full || res_ready);
        any     = p_valid[0] || p_valid[1];
        g       = (p_valid[0] && p_valid[1]) ? tie_port() : !p_valid[0];
        obs_r0  = req0_ready;
        obs_r1  = req1_ready;
        chk_bit("req0_ready", req0_ready, can_acc && any && !g);
        chk_bit("req1_ready", req1_ready, can_acc && any && g);
        @(posedge clk);
        if (!rst) begin
            m_full = 1'b0;
            m_data = '0;
            m_id   = 1'b0;
            m_err  = 1'b0;
            m_last = 1'b1;
        end else if (can_acc && any) begin
            ref_alu(p_cmd[g], p_a[g], p_b[g], r, e);
            m_data     = r;
            m_err      = e;
            m_id       = g;
            m_full     = 1'b1;
            m_last     = g;
            p_valid[g] = 1'b0;
        end else if (m_full && res_ready) begin
            m_full = 1'b0;
        end
        #1;
        chk_bit("res_valid", res_valid, m_full);
        chk_word("res_data", res_data, m_data);
        chk_bit("res_id", res_id, m_id);
        chk_bit("res_err", res_err, m_err);
    endtask

    task automatic issue_random(input int p);
        logic [3:0]   c;
        logic [W-1:0] b;
        if ($urandom_range(0, 9) == 0) c = bad_cmds[$urandom_range(0, 6)];
        else                           c = legal_cmds[$urandom_range(0, 8)];
        b = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 40));
        issue(p, c, W'($urandom), b);
    endtask

    initial begin
        logic exp_id;
        p_valid   = '{1'b0, 1'b0};
        p_cmd     = '{4'h0, 4'h0};
        p_a       = '{'0, '0};
        p_b       = '{'0, '0};
        m_full    = 1'b0;
        m_data    = '0;
        m_id      = 1'b0;
        m_err     = 1'b0;
        m_last    = 1'b1;
        rst       = 1'b0;
        res_ready = 1'b0;

        // Reset state.
        run_cycle();
        run_cycle();
        chk_bit("rst_valid", res_valid, 1'b0);
        chk_word("rst_data", res_data, '0);
        rst = 1'b1;

        // Single request: 5 + 7.
        res_ready = 1'b1;
        issue(0, 4'h0, 32'd5, 32'd7);
        run_cycle();
        chk_bit("t1_ready", obs_r0, 1'b1);
        chk_word("t1_data", res_data, 32'd12);
        chk_bit("t1_id", res_id, 1'b0);

        // Tie after a fresh reset: results alternate 0,1,... (or all 0).
        rst = 1'b0;
        run_cycle();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!p_valid[0]) issue(0, 4'h2, 32'd3, 32'd5);
            if (!p_valid[1]) issue(1, 4'h7, 32'hF0F0_0000, 32'h0F0F_0000);
            run_cycle();
`ifdef ALU_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            chk_bit("tie_id", res_id, exp_id);
            chk_word("tie_data", res_data, exp_id ? 32'hFFFF_0000 : 32'hFFFF_FFFE);
        end
        p_valid = '{1'b0, 1'b0};
        run_cycle();

        // Backpressure: the result is held, then the pending request
        // goes through with no bubble.
        issue(0, 4'h4, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_cycle();
        res_ready = 1'b0;
        issue(0, 4'h5, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk_word("bp_hold", res_data, 32'h0F00_0F00);
            chk_bit("bp_ready", obs_r0, 1'b0);
        end
        res_ready = 1'b1;
        run_cycle();
        chk_bit("bp_no_bubble", obs_r0, 1'b1);
        chk_word("bp_data", res_data, 32'h3);

        // Illegal command, then a legal one.
        issue(1, 4'b0011, 32'd1, 32'd1);
        run_cycle();
        chk_bit("ill_err", res_err, 1'b1);
        chk_word("ill_data", res_data, '0);
        issue(1, 4'h5, 32'h0F, 32'hF0);
        run_cycle();
        chk_word("or_data", res_data, 32'hFF);
        chk_bit("or_err", res_err, 1'b0);

        // Shift and NOR edge cases.
        issue(0, 4'h8, 32'd1, 32'd31);
        run_cycle();
        chk_word("sll31", res_data, 32'h8000_0000);
        issue(0, 4'hA, 32'h8000_0000, 32'd32);
        run_cycle();
        chk_word("srl32", res_data, 32'h0);
        issue(0, 4'h6, 32'h0, 32'h0);
        run_cycle();
        chk_word("nor00", res_data, 32'hFFFF_FFFF);
        issue(1, 4'h9, 32'h8000_0000, 32'd40);
        run_cycle();
        chk_word("sra40", res_data, 32'hFFFF_FFFF);

        // Reset while stalled on a full buffer.
        issue(1, 4'h0, 32'd1, 32'd2);
        run_cycle();
        res_ready = 1'b0;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        chk_bit("rst_stall_valid", res_valid, 1'b0);
        chk_word("rst_stall_data", res_data, '0);
        rst = 1'b1;
        res_ready = 1'b1;
        issue(0, 4'h0, 32'd10, 32'd20);
        issue(1, 4'h0, 32'd30, 32'd40);
        run_cycle();
        chk_bit("rst_tie_id", res_id, 1'b0);
        p_valid = '{1'b0, 1'b0};
        run_cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++)
                if (!p_valid[p] && $urandom_range(0, 3) != 0) issue_random(p);
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) != 0);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
